// File: rtl/pipe_rca_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_rca_adder_pkg
//  Description : Shared types and helpers for the pipelined ripple-carry adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_rca_adder_pkg;

    // Per-stage control record; the data slices live in parallel arrays
    // because their widths follow the top-level WIDTH parameter.
    typedef struct packed {
        logic valid;
        logic carry;
        logic c_msb;
    } stage_ctrl_t;

    function automatic logic signed_ovf(input logic c_msb_in, input logic c_out);
        return c_msb_in ^ c_out;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_rca_adder_rca_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : rca_chunk
//  Description : Combinational CHUNK-bit ripple-carry slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic w_c;

    always_comb begin
        w_c      = cin;
        c_msb_in = cin;
        s        = '0;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                c_msb_in = w_c;
            end
            s[i] = a[i] ^ b[i] ^ w_c;
            w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
        end
        cout = w_c;
    end

endmodule
`default_nettype wire

// File: rtl/pipe_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_rca_adder
//  Description : Pipelined ripple-carry adder/subtractor with valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_rca_adder
    import pipe_rca_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_rca_adder: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic             w_c_in;

    stage_ctrl_t      r_ctrl [STAGES];
    logic [WIDTH-1:0] r_sum  [STAGES];
    logic [WIDTH-1:0] r_a    [STAGES];
    logic [WIDTH-1:0] r_b    [STAGES];

    logic [CHUNK-1:0] w_ca   [STAGES];
    logic [CHUNK-1:0] w_cb   [STAGES];
    logic [CHUNK-1:0] w_s    [STAGES];
    logic             w_cin  [STAGES];
    logic             w_cout [STAGES];
    logic             w_cmsb [STAGES];

    assign w_adv    = !r_ctrl[LAST].valid || out_ready;
    assign in_ready = w_adv;

    // Idle input cycles load zeros so no X enters the pipeline from the bus.
    assign w_a_in = in_valid ? a : '0;
    assign w_b_in = in_valid ? (sub ? ~b : b) : '0;
    assign w_c_in = in_valid & c_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_ca[k]  = w_a_in[CHUNK-1:0];
            assign w_cb[k]  = w_b_in[CHUNK-1:0];
            assign w_cin[k] = w_c_in;
        end else begin : g_rest
            assign w_ca[k]  = r_a[k-1][k*CHUNK +: CHUNK];
            assign w_cb[k]  = r_b[k-1][k*CHUNK +: CHUNK];
            assign w_cin[k] = r_ctrl[k-1].carry;
        end

        rca_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a        (w_ca[k]),
            .b        (w_cb[k]),
            .cin      (w_cin[k]),
            .s        (w_s[k]),
            .cout     (w_cout[k]),
            .c_msb_in (w_cmsb[k])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_ctrl[k] <= '0;
                r_sum[k]  <= '0;
                r_a[k]    <= '0;
                r_b[k]    <= '0;
            end
        end else if (w_adv) begin
            r_ctrl[0] <= '{valid: in_valid, carry: w_cout[0], c_msb: w_cmsb[0]};
            r_sum[0]  <= WIDTH'(w_s[0]);
            r_a[0]    <= w_a_in;
            r_b[0]    <= w_b_in;
            // Each later stage fills in its own slice of the partial sum.
            for (int k = 1; k < STAGES; k++) begin
                r_ctrl[k] <= '{valid: r_ctrl[k-1].valid, carry: w_cout[k], c_msb: w_cmsb[k]};
                r_sum[k]  <= r_sum[k-1];
                r_sum[k][k*CHUNK +: CHUNK] <= w_s[k];
                r_a[k]    <= r_a[k-1];
                r_b[k]    <= r_b[k-1];
            end
        end
    end

    assign out_valid = r_ctrl[LAST].valid;
    assign sum       = r_sum[LAST];
    assign c_out     = r_ctrl[LAST].carry;
    assign ovf       = signed_ovf(r_ctrl[LAST].c_msb, r_ctrl[LAST].carry);

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_rca_adder
//  Description : Self-checking bench with arithmetic scoreboard for pipe_rca_adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_rca_adder;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int n_checks = 0;
    int n_errors = 0;

    logic [17:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [18:0] held;
    logic        rand_done;

    pipe_rca_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic; overflow is the signed result leaving range.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] beff;
        int unsigned usum;
        int          ssum;
        logic        v;
        beff = msub ? ~mb : mb;
        usum = int'(ma) + int'(beff) + int'(mcin);
        ssum = int'($signed(ma)) + int'($signed(beff)) + int'(mcin);
        v    = (ssum > 32767) || (ssum < -32768);
        return {usum[16], v, usum[15:0]};
    endfunction

    // Handshakes are judged half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_out", 32'({out_valid, c_out, ovf, sum}), 32'(held));
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, c_out, ovf, sum};
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in, sub));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    check("result", 32'({c_out, ovf, sum}), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [15:0] sa, input logic [15:0] sb,
                        input logic scin, input logic ssub);
        int tries;
        a = sa; b = sb; c_in = scin; sub = ssub; in_valid = 1'b1;
        tries = 0;
        forever begin
            @(negedge clk);
            if (in_ready || tries >= 200) break;
            tries++;
            @(posedge clk); #1;
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 50);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        out_ready = 1'b1; rand_done = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'h0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Carry rippling through every chunk
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        check("t2_latency", 32'(lat),   32'(STAGES - 1));
        check("t2_sum",     32'(sum),   32'h0000);
        check("t2_c_out",   32'(c_out), 32'd1);
        check("t2_ovf",     32'(ovf),   32'd0);
        drain();

        // Signed overflow, then subtraction
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_out(lat);
        check("t3_sum", 32'(sum),   32'h8000);
        check("t3_c",   32'(c_out), 32'd0);
        check("t3_ovf", 32'(ovf),   32'd1);
        drain();
        send(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_out(lat);
        check("t3s_sum", 32'(sum),   32'hFFFE);
        check("t3s_c",   32'(c_out), 32'd0);
        check("t3s_ovf", 32'(ovf),   32'd0);
        drain();

        // Back-to-back stream with a three-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), i[0], i[1]);
                end
            end
            begin
                int n;
                n = 0;
                do begin
                    @(posedge clk); #1;
                    n++;
                end while (!out_valid && n < 50);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t4_ready_stall", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                @(negedge clk);
                check("t4_ready_resume", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Reset with operations in flight
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b1, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("t5_no_out", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;
        send(16'h0102, 16'h0304, 1'b0, 1'b0);
        wait_out(lat);
        check("t5_latency", 32'(lat), 32'(STAGES - 1));
        check("t5_sum",     32'(sum), 32'h0406);
        drain();

        // Randomised traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(2) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
